hsv_core_commit_writeback: RTL

// - Commit stage directly downstream of the ALU execute pipe: consumes one exec result per accepted handshake.
// - Writes the register file and releases the pending-write scoreboard bit that issue uses for RAW hazards.
// - Counts retired instructions.
// - On a trapping result: drains the core through flush_req/flush_ack, then redirects fetch to TRAP_VECTOR.

---
 rtl/hsv_core_commit_writeback.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/hsv_core_commit_writeback.sv
// Commit/writeback stage: retires ALU results into the register file, maintains the
// pending-write scoreboard, counts retirements and sequences trap flush and redirect.
module hsv_core_commit_writeback #(
  parameter int                XLEN        = 32,
  parameter logic [XLEN-1:0]   TRAP_VECTOR = 32'h0000_0100,
  parameter int                RETIRE_W    = 64
) (
  input  logic                clk_core,
  input  logic                rst_core,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          in_rd,
  input  logic                in_writeback,
  input  logic [XLEN-1:0]     in_result,
  input  logic [XLEN-1:0]     in_pc,
  input  logic                in_trap,
  input  logic                issue_set,
  input  logic [4:0]          issue_rd,
  output logic [31:0]         busy_mask,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic                flush_req,
  input  logic                flush_ack,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc,
  output logic [XLEN-1:0]     trap_pc,
  output logic [RETIRE_W-1:0] retired,
  output logic [1:0]          dbg_state_o
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  // Handshake: a result transfers on a cycle where in_valid && in_ready; in_ready
  // depends on state only, and in_valid is expected to hold its payload until then.
  logic [1:0]          state_q, state_d;
  logic [31:0]         busy_q, busy_d;
  logic                rf_we_q, rf_we_d;
  logic [4:0]          rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]     rf_wdata_q, rf_wdata_d;
  logic                flush_req_q, flush_req_d;
  logic                redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]     redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0]     trap_pc_q, trap_pc_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  logic fire;
  logic wr_fire;
  logic flush_done;

  assign in_ready   = (state_q == ST_RUN);
  assign fire       = in_valid & in_ready;
  assign wr_fire    = fire & ~in_trap & in_writeback & (in_rd != 5'd0);
  assign flush_done = (state_q == ST_FLUSH) & flush_req_q & flush_ack;

  always_comb begin
    state_d          = state_q;
    flush_req_d      = flush_req_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    trap_pc_d        = trap_pc_q;
    case (state_q)
      ST_RUN: begin
        flush_req_d = 1'b0;
        if (fire && in_trap) begin
          state_d     = ST_FLUSH;
          flush_req_d = 1'b1;
          trap_pc_d   = in_pc;
        end
      end
      ST_FLUSH: begin
        flush_req_d = 1'b1;
        if (flush_done) begin
          state_d          = ST_REDIRECT;
          flush_req_d      = 1'b0;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = TRAP_VECTOR;
        end
      end
      ST_REDIRECT: begin
        flush_req_d = 1'b0;
        state_d     = ST_RUN;
      end
      default: begin
        flush_req_d = 1'b0;
        state_d     = ST_RUN;
      end
    endcase
  end

  always_comb begin
    rf_we_d    = wr_fire;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wr_fire) begin
      rf_waddr_d = in_rd;
      rf_wdata_d = in_result;
    end
  end

  // Clear first, then set, so a same-cycle issue of the same rd stays pending.
  always_comb begin
    busy_d = busy_q;
    if (wr_fire) begin
      busy_d[in_rd] = 1'b0;
    end
    if (issue_set && (issue_rd != 5'd0) && (state_q != ST_FLUSH)) begin
      busy_d[issue_rd] = 1'b1;
    end
    if (flush_done) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    retired_d = retired_q;
    if (fire && !in_trap) begin
      retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q          <= ST_RUN;
      busy_q           <= '0;
      rf_we_q          <= 1'b0;
      rf_waddr_q       <= '0;
      rf_wdata_q       <= '0;
      flush_req_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      trap_pc_q        <= '0;
      retired_q        <= '0;
    end else begin
      state_q          <= state_d;
      busy_q           <= busy_d;
      rf_we_q          <= rf_we_d;
      rf_waddr_q       <= rf_waddr_d;
      rf_wdata_q       <= rf_wdata_d;
      flush_req_q      <= flush_req_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      trap_pc_q        <= trap_pc_d;
      retired_q        <= retired_d;
    end
  end

  assign busy_mask      = busy_q;
  assign rf_we          = rf_we_q;
  assign rf_waddr       = rf_waddr_q;
  assign rf_wdata       = rf_wdata_q;
  assign flush_req      = flush_req_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign trap_pc        = trap_pc_q;
  assign retired        = retired_q;
  assign dbg_state_o    = state_q;

endmodule
